// File: rtl/dac_stream_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, DAC command codes and frame layout for the DAC streaming engine.
package dac_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IDLE_GRP,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    GAP,
    LDAC
  } state_t;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_WRITE_INPUT  = 4'b0001;
  localparam int         FRAME_BITS       = 24;

  // Frame word: command nibble, 16-bit left-justified sample, four zero pad bits.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0]  cmd,
                                                        input logic [15:0] data16);
    return {cmd, data16, 4'b0000};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
// Single-clock FIFO with registered full/empty flags and an occupancy count.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [AW:0]      level_d;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    level_d = level;
    if (do_push && !do_pop) level_d = level + 1'b1;
    else if (do_pop && !do_push) level_d = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_d;
      full  <= (level_d == (AW+1)'(DEPTH));
      empty <= (level_d == '0);
    end
  end

endmodule

// File: rtl/dac_stream_controller.sv
`timescale 1ns/1ps
// Paced multi-channel SPI DAC streamer: FIFO-buffered samples serialised as 24-bit frames
// on a shared SCLK/MOSI with one active-low sync per channel and optional grouped LDAC.
module dac_stream_controller
  import dac_stream_pkg::*;
#(
  parameter  int CHANNELS   = 2,
  parameter  int DATA_WIDTH = 12,
  parameter  int FIFO_DEPTH = 16,
  parameter  int CLK_DIV    = 4,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [15:0]           rateDiv,
  // Write handshake: an entry is taken on a rising clk edge where wrValid && wrReady;
  // wrReady depends only on registered FIFO state, never on wrValid.
  input  logic                  wrValid,
  output logic                  wrReady,
  input  logic [CH_W-1:0]       wrChannel,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  wrLast,
  output logic [LVL_W-1:0]      fifoLevel,
  output logic                  busy,
  output logic                  underflow,
  output logic                  overrun,
  input  logic                  clearFlags,
  output logic                  dacSclk,
  output logic                  dacMosi,
  output logic [CHANNELS-1:0]   dacSs,
  output logic                  dacLdacn,
  output state_t                dbg_state
);

  localparam int EW    = 1 + CH_W + DATA_WIDTH;
  localparam int DIV_W = $clog2(CLK_DIV) + 1;

  state_t                  state_q, state_d;
  logic [EW-1:0]           rd_entry;
  logic                    fifo_full, fifo_empty, pop;
  logic                    rd_last;
  logic [CH_W-1:0]         rd_ch;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [15:0]             data16;
  logic [15:0]             rate_cnt;
  logic                    paced, tick, start;
  logic [DIV_W-1:0]        div_cnt;
  logic                    phase_end;
  logic [4:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [CH_W-1:0]         cur_ch;
  logic                    cur_mode, cur_last;
  logic                    in_frame;

  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wrValid),
    .pop   (pop),
    .wdata ({wrLast, wrChannel, wrData}),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifoLevel)
  );

  assign wrReady = !fifo_full;
  assign {rd_last, rd_ch, rd_data} = rd_entry;
  assign data16    = 16'(rd_data) << (16 - DATA_WIDTH);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Pacing: tick once every rateDiv+1 enabled clocks; rateDiv == 0 means free-running.
  assign paced = (rateDiv != 16'd0);
  assign tick  = enable && paced && (rate_cnt >= rateDiv);
  assign start = enable && !fifo_empty && (!paced || tick);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rate_cnt <= '0;
    end else if (!enable || !paced || (rate_cnt >= rateDiv)) begin
      rate_cnt <= '0;
    end else begin
      rate_cnt <= rate_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underflow <= 1'b0;
      overrun   <= 1'b0;
    end else if (clearFlags) begin
      underflow <= 1'b0;
      overrun   <= 1'b0;
    end else if (tick) begin
      if (busy) overrun <= 1'b1;
      else if (fifo_empty) underflow <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          pop     = 1'b1;
        end
      end
      IDLE_GRP: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (!fifo_empty) begin
          state_d = SETUP;
          pop     = 1'b1;
        end
      end
      SETUP: if (phase_end) state_d = LOW;
      LOW:   if (phase_end) state_d = HIGH;
      HIGH:  if (phase_end) state_d = (bit_cnt == 5'(FRAME_BITS - 1)) ? HOLD : LOW;
      HOLD:  if (phase_end) state_d = GAP;
      GAP: begin
        // A group continues back-to-back until its last entry; LDAC only closes grouped frames.
        if (phase_end) begin
          if (cur_last) begin
            state_d = cur_mode ? LDAC : IDLE;
          end else if (!enable) begin
            state_d = IDLE;
          end else if (fifo_empty) begin
            state_d = IDLE_GRP;
          end else begin
            state_d = SETUP;
            pop     = 1'b1;
          end
        end
      end
      LDAC:    if (phase_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      cur_ch   <= '0;
      cur_mode <= 1'b0;
      cur_last <= 1'b0;
    end else begin
      state_q <= state_d;
      div_cnt <= (state_d != state_q) ? '0 : div_cnt + 1'b1;
      if (pop) begin
        shift_q  <= build_frame(mode ? CMD_WRITE_INPUT : CMD_WRITE_UPDATE, data16);
        cur_ch   <= rd_ch;
        cur_mode <= mode;
        cur_last <= rd_last;
        bit_cnt  <= '0;
      end else begin
        if (state_q == LOW && phase_end) shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
        if (state_q == HIGH && phase_end) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Out-of-range channels still run the full frame timing but leave every sync line high.
  always_comb begin
    in_frame = (state_q == SETUP) || (state_q == LOW) || (state_q == HIGH) || (state_q == HOLD);
    dacSclk  = (state_q != LOW);
    dacMosi  = in_frame ? shift_q[FRAME_BITS-1] : 1'b0;
    dacLdacn = (state_q != LDAC);
    dacSs    = '1;
    for (int i = 0; i < CHANNELS; i++) begin
      dacSs[i] = !(in_frame && (int'(cur_ch) == i));
    end
  end

endmodule

// File: tb/tb_dac_stream_controller.sv
`timescale 1ns/1ps
// Bench for dac_stream_controller: pin-level frame decoder plus an expected-frame queue
// built from pushed samples, with directed pacing, overrun, full-FIFO and reset scenarios.
module tb_dac_stream_controller;
  import dac_stream_pkg::*;

  localparam int CHANNELS   = 2;
  localparam int DATA_WIDTH = 12;
  localparam int FIFO_DEPTH = 16;
  localparam int CLK_DIV    = 2;
  localparam int W          = 25;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  enable = 1'b0;
  logic                  mode = 1'b0;
  logic [15:0]           rateDiv = 16'd0;
  logic                  wrValid = 1'b0;
  logic [0:0]            wrChannel = 1'b0;
  logic [DATA_WIDTH-1:0] wrData = '0;
  logic                  wrLast = 1'b0;
  logic                  clearFlags = 1'b0;
  logic                  wrReady, busy, underflow, overrun;
  logic                  dacSclk, dacMosi, dacLdacn;
  logic [4:0]            fifoLevel;
  logic [1:0]            dacSs;
  state_t                dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  int fall_q[$];

  // Frame monitor state
  logic        mon_active = 1'b0;
  logic        mon_ch = 1'b0;
  logic [23:0] mon_word = '0;
  logic [23:0] last_word = '0;
  int          mon_len = 0, mon_bits = 0, frames_done = 0, last_rise_cyc = 0;
  logic        prev_sclk = 1'b1;
  logic        ldac_low = 1'b0;
  int          ldac_len = 0, ldac_pulses = 0;

  dac_stream_controller #(
    .CHANNELS(CHANNELS), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .rateDiv(rateDiv),
    .wrValid(wrValid), .wrReady(wrReady), .wrChannel(wrChannel), .wrData(wrData),
    .wrLast(wrLast), .fifoLevel(fifoLevel), .busy(busy), .underflow(underflow),
    .overrun(overrun), .clearFlags(clearFlags), .dacSclk(dacSclk), .dacMosi(dacMosi),
    .dacSs(dacSs), .dacLdacn(dacLdacn), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] frame_word(input logic m, input logic [11:0] d);
    return {(m ? 4'h1 : 4'h3), d, 8'h00};
  endfunction

  // Called just after a falling clk edge; returns at the falling edge after acceptance.
  task automatic push(input int ch, input logic [DATA_WIDTH-1:0] d, input logic last);
    int  n;
    bit  ok;
    n  = 0;
    wrChannel = ch[0];
    wrData    = d;
    wrLast    = last;
    wrValid   = 1'b1;
    while (!wrReady && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = wrReady;
    if (ok) exp_q.push_back({ch[0], frame_word(mode, d)});
    @(negedge clk);
    wrValid = 1'b0;
    check_eq("push_accept", 32'(ok), 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((busy || fifoLevel != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_in_budget", 32'(n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Decode frames straight from the pins and score them against the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 1'b0;
      prev_sclk  = 1'b1;
      ldac_low   = 1'b0;
    end else begin
      if (dacSs != 2'b11) begin
        if (!mon_active) begin
          mon_active = 1'b1;
          mon_ch     = dacSs[0] ? 1'b1 : 1'b0;
          mon_len    = 0;
          mon_bits   = 0;
          mon_word   = '0;
          fall_q.push_back(cyc);
          check_eq("ss_onehot", $countones(~dacSs), 1);
        end
        mon_len++;
        if (prev_sclk && !dacSclk) begin
          mon_word = {mon_word[22:0], dacMosi};
          mon_bits++;
        end
      end else if (mon_active) begin
        mon_active    = 1'b0;
        last_rise_cyc = cyc;
        last_word     = mon_word;
        frames_done++;
        check_eq("ss_low_len", mon_len, 50 * CLK_DIV);
        check_eq("frame_bits", mon_bits, 24);
        check_eq("frame_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("frame_word", {mon_ch, mon_word}, exp_q.pop_front());
      end
      if (!dacLdacn) begin
        if (!ldac_low) begin
          ldac_low = 1'b1;
          ldac_len = 0;
          check_eq("ldac_delay", cyc - last_rise_cyc, CLK_DIV);
          check_eq("ldac_outside_frame", 32'(mon_active), 0);
        end
        ldac_len++;
      end else if (ldac_low) begin
        ldac_low = 1'b0;
        ldac_pulses++;
        check_eq("ldac_width", ldac_len, CLK_DIV);
      end
      prev_sclk = dacSclk;
    end
  end

  initial begin
    int base_ldac, base_frames, n, sz, t_under;
    logic m;

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    check_eq("rst_ss", dacSs, 2'b11);
    check_eq("rst_sclk", dacSclk, 1);
    check_eq("rst_mosi", dacMosi, 0);
    check_eq("rst_ldacn", dacLdacn, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_flags", {underflow, overrun}, 0);
    check_eq("rst_ready", wrReady, 1);
    check_eq("rst_level", fifoLevel, 0);
    check_eq("rst_state", dbg_state, IDLE);
    reset = 1'b1;
    @(negedge clk);

    // Immediate update, single frame
    mode = 1'b0;
    enable = 1'b1;
    push(0, 12'hABC, 1'b1);
    wait_drain(500);
    check_eq("a_word", last_word, 24'h3ABC00);
    check_eq("a_frames", frames_done, 1);
    check_eq("a_no_ldac", ldac_pulses, 0);

    // Grouped update across two channels
    mode = 1'b1;
    push(0, 12'h123, 1'b0);
    push(1, 12'h456, 1'b1);
    wait_drain(800);
    check_eq("b_word", last_word, 24'h145600);
    check_eq("b_frames", frames_done, 3);
    check_eq("b_ldac", ldac_pulses, 1);

    // Random groups, random mode per group, random inter-push gaps
    for (int g = 0; g < 6; g++) begin
      sz = $urandom_range(1, 4);
      m  = 1'($urandom_range(0, 1));
      mode = m;
      base_ldac = ldac_pulses;
      for (int k = 0; k < sz; k++) begin
        push($urandom_range(0, 1), 12'($urandom), (k == sz - 1));
        wait_cycles($urandom_range(0, 40));
      end
      wait_drain(3000);
      check_eq("rnd_ldac", ldac_pulses - base_ldac, 32'(m));
    end
    check_eq("rnd_q_empty", exp_q.size(), 0);

    // Fill with engine disabled: 16 accepted, 17th held
    enable = 1'b0;
    mode = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      push(i % 2, 12'($urandom), ($urandom_range(0, 1) == 1) || (i == FIFO_DEPTH - 1));
      check_eq("fill_level", fifoLevel, i + 1);
    end
    check_eq("full_ready", wrReady, 0);
    wrChannel = 1'b0;
    wrData = 12'h777;
    wrLast = 1'b1;
    wrValid = 1'b1;
    wait_cycles(5);
    check_eq("full_hold_level", fifoLevel, FIFO_DEPTH);
    wrValid = 1'b0;
    base_frames = frames_done;
    enable = 1'b1;
    wait_drain(4000);
    check_eq("full_drain_frames", frames_done - base_frames, FIFO_DEPTH);
    check_eq("full_q_empty", exp_q.size(), 0);

    // Paced groups 1000 clocks apart, then underflow on an empty tick
    enable = 1'b0;
    rateDiv = 16'd999;
    for (int i = 0; i < 3; i++) push(i % 2, 12'($urandom), 1'b1);
    fall_q.delete();
    enable = 1'b1;
    n = 0;
    while (fall_q.size() < 3 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_eq("pace_starts", fall_q.size(), 3);
    if (fall_q.size() >= 3) begin
      check_eq("pace_gap1", fall_q[1] - fall_q[0], 1000);
      check_eq("pace_gap2", fall_q[2] - fall_q[1], 1000);
    end
    check_eq("pace_no_under_yet", underflow, 0);
    n = 0;
    while (!underflow && n < 1500) begin
      @(negedge clk);
      n++;
    end
    t_under = cyc;
    check_eq("under_set", underflow, 1);
    if (fall_q.size() >= 3) check_eq("under_time", t_under - fall_q[2], 1000);
    check_eq("pace_no_over", overrun, 0);

    // clearFlags wins over same-cycle set, then flags re-set and clear
    rateDiv = 16'd50;
    clearFlags = 1'b1;
    wait_cycles(120);
    check_eq("clear_priority", underflow, 0);
    clearFlags = 1'b0;
    wait_cycles(60);
    check_eq("under_reset_again", underflow, 1);
    enable = 1'b0;
    clearFlags = 1'b1;
    @(negedge clk);
    clearFlags = 1'b0;
    @(negedge clk);
    check_eq("clear_under", underflow, 0);
    check_eq("clear_over", overrun, 0);

    // Overrun: ticks during a two-frame group are dropped
    push(0, 12'($urandom), 1'b0);
    push(1, 12'($urandom), 1'b1);
    base_frames = frames_done;
    enable = 1'b1;
    wait_cycles(400);
    enable = 1'b0;
    wait_drain(500);
    check_eq("ovr_set", overrun, 1);
    check_eq("ovr_under_after", underflow, 1);
    check_eq("ovr_frames", frames_done - base_frames, 2);
    check_eq("ovr_q_empty", exp_q.size(), 0);

    // Reset during a LOW phase
    rateDiv = 16'd0;
    clearFlags = 1'b1;
    @(negedge clk);
    clearFlags = 1'b0;
    for (int i = 0; i < 3; i++) push(i % 2, 12'($urandom), 1'b1);
    enable = 1'b1;
    n = 0;
    while (dacSclk && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_low_reached", dacSclk, 0);
    #1 reset = 1'b0;
    #1;
    check_eq("arst_ss", dacSs, 2'b11);
    check_eq("arst_sclk", dacSclk, 1);
    check_eq("arst_mosi", dacMosi, 0);
    check_eq("arst_busy", busy, 0);
    enable = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("arst_level", fifoLevel, 0);
    check_eq("arst_ready", wrReady, 1);
    check_eq("arst_flags", {underflow, overrun}, 0);

    // One clean frame after reset
    mode = 1'b0;
    base_frames = frames_done;
    enable = 1'b1;
    push(1, 12'h5A5, 1'b1);
    wait_drain(500);
    check_eq("post_rst_frames", frames_done - base_frames, 1);
    check_eq("post_rst_word", last_word, 24'h35A500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
